// File: rtl/set_duty_pkg.sv
// Shared widths and duty/gap types for the set_duty_ramp slew limiter.
package set_duty_pkg;

  localparam int unsigned DUTY_W_DEF = 20;
  localparam int unsigned GAP_W_DEF  = 12;

  typedef logic [DUTY_W_DEF-1:0] duty_t;
  typedef logic [GAP_W_DEF-1:0]  gap_t;

endpackage

// File: rtl/set_duty_tick.sv
// Step prescaler: one-cycle tick every STEP_DIV clocks, first tick STEP_DIV edges after reset.
module set_duty_tick #(
  parameter int unsigned STEP_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(STEP_DIV - 1);

  logic [15:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/set_duty_ramp.sv
// Slew-rate limiter for a PWM duty command: duty_out steps toward duty_need by at most duty_gap per tick.
// Optional `SET_DUTY_DONE_EN adds the registered duty_done output.
module set_duty_ramp
  import set_duty_pkg::*;
#(
  parameter int unsigned        DUTY_W   = DUTY_W_DEF,
  parameter int unsigned        GAP_W    = GAP_W_DEF,
  parameter int unsigned        STEP_DIV = 1,
  parameter logic [DUTY_W-1:0]  RST_DUTY = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] duty_need,
  input  logic [GAP_W-1:0]  duty_gap,
  output logic [DUTY_W-1:0] duty_out
`ifdef SET_DUTY_DONE_EN
  ,
  output logic              duty_done
`endif
);

  logic              tick;
  logic              up;
  logic [DUTY_W:0]   need_x;
  logic [DUTY_W:0]   out_x;
  logic [DUTY_W:0]   gap_x;
  logic [DUTY_W:0]   diff;
  logic [DUTY_W:0]   step;
  logic [DUTY_W-1:0] duty_next;

  set_duty_tick #(
    .STEP_DIV (STEP_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Step is clamped to the remaining distance, so neither overshoot nor wrap can occur.
  always_comb begin
    need_x    = {1'b0, duty_need};
    out_x     = {1'b0, duty_out};
    gap_x     = (DUTY_W + 1)'(duty_gap);
    up        = (duty_need > duty_out);
    diff      = up ? (need_x - out_x) : (out_x - need_x);
    step      = (gap_x < diff) ? gap_x : diff;
    duty_next = up ? (duty_out + DUTY_W'(step)) : (duty_out - DUTY_W'(step));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_out <= RST_DUTY;
    end else if (tick) begin
      duty_out <= duty_next;
    end
  end

`ifdef SET_DUTY_DONE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_done <= 1'b0;
    end else begin
      duty_done <= (duty_out == duty_need);
    end
  end
`endif

endmodule

// File: tb/tb_set_duty_ramp.sv
// Self-checking bench for set_duty_ramp: table-driven ramp vectors plus reset and prescaler sequences.
module tb_set_duty_ramp;
  import set_duty_pkg::*;

  localparam logic [19:0] MAXV = 20'hFFFFF;

  typedef struct {
    string nm;
    duty_t need;
    gap_t  gap;
    duty_t exp;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  duty_t need_a = '0;
  gap_t  gap_a = '0;
  duty_t out_a;
  duty_t need_b = '0;
  gap_t  gap_b = '0;
  duty_t out_b;
`ifdef SET_DUTY_DONE_EN
  logic  done_a;
  logic  done_b;
`endif

  int total = 0;
  int bad = 0;
  vec_t q[$];

  always #5 clk = ~clk;

  set_duty_ramp #(.STEP_DIV(1)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .duty_need (need_a),
    .duty_gap  (gap_a),
    .duty_out  (out_a)
`ifdef SET_DUTY_DONE_EN
    ,
    .duty_done (done_a)
`endif
  );

  set_duty_ramp #(.STEP_DIV(4)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .duty_need (need_b),
    .duty_gap  (gap_b),
    .duty_out  (out_b)
`ifdef SET_DUTY_DONE_EN
    ,
    .duty_done (done_b)
`endif
  );

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void add(input string nm, input longint need, input longint gap, input longint exp);
    vec_t v;
    v.nm   = nm;
    v.need = duty_t'(need);
    v.gap  = gap_t'(gap);
    v.exp  = duty_t'(exp);
    q.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    longint e;

    // Hand-computed ramp vectors, one clock each.
    for (int k = 1; k <= 20; k++) add("ramp_up5", 100, 5, 5 * k);
    add("hold100", 100, 5, 100);
    add("hold100", 100, 5, 100);
    for (int k = 1; k <= 13; k++) add("down7", 3, 7, 100 - 7 * k);
    add("down7_end", 3, 7, 3);
    add("hold3", 3, 7, 3);
    add("to0", 0, 7, 0);
    for (int k = 1; k <= 14; k++) add("up7", 100, 7, 7 * k);
    add("up7_end", 100, 7, 100);
    add("hold100b", 100, 7, 100);
    add("bigdrop", 0, 100, 0);
    for (int k = 1; k <= 10; k++) add("up5", 100, 5, 5 * k);
    for (int k = 1; k <= 6; k++) add("retarget", 20, 5, 50 - 5 * k);
    add("hold20", 20, 5, 20);
    for (int k = 0; k < 3; k++) add("gap0", 500, 0, 20);
    add("gap0_low", 0, 0, 20);
    for (int k = 1; k <= 257; k++) begin
      e = 20 + 4095 * longint'(k);
      if (e > longint'(MAXV)) e = longint'(MAXV);
      add("to_max", MAXV, 4095, e);
    end
    add("hold_max", MAXV, 4095, MAXV);
    for (int k = 1; k <= 257; k++) begin
      e = longint'(MAXV) - 4095 * longint'(k);
      if (e < 0) e = 0;
      add("to_zero", 0, 4095, e);
    end
    add("hold_zero", 0, 4095, 0);

    // Reset holds outputs at RST_DUTY regardless of inputs.
    need_a = 20'd100;
    gap_a  = 12'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_a", out_a, 0);
      check("rst_b", out_b, 0);
`ifdef SET_DUTY_DONE_EN
      check("rst_done", done_a, 0);
`endif
    end

    @(negedge clk);
    rst_n = 1'b1;
    foreach (q[i]) begin
      need_a = q[i].need;
      gap_a  = q[i].gap;
      @(posedge clk);
      #1;
      check(q[i].nm, out_a, q[i].exp);
      @(negedge clk);
    end
    check("b_idle", out_b, 0);

    // Asynchronous reset mid-ramp takes effect without a clock edge.
    need_a = 20'd1000;
    gap_a  = 12'd5;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      check("pre_async", out_a, 5 * i);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", out_a, 0);

    // Prescaler: STEP_DIV=4 steps on every 4th edge after release.
    @(negedge clk);
    rst_n  = 1'b1;
    need_b = 20'd20;
    gap_b  = 12'd5;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      check("presc", out_b, 5 * (c / 4));
`ifdef SET_DUTY_DONE_EN
      check("done_low", done_b, 0);
`endif
    end
    @(posedge clk);
    #1;
    check("presc_hold", out_b, 20);
`ifdef SET_DUTY_DONE_EN
    check("done_rise", done_b, 1);
`endif
    @(negedge clk);
    need_b = 20'd40;
    @(posedge clk);
    #1;
    check("presc_hold2", out_b, 20);
`ifdef SET_DUTY_DONE_EN
    check("done_fall", done_b, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
